// File: rtl/sweep_pkg.sv
// sweep_pkg: shared definitions for the mode-sweep controller.
//   state_t    - sweep FSM states (also visible on the STATE debug port)
//   MODE_OFF   - main-mode value meaning "all stimulus disabled"
//   sat_err32  - saturate a 64-bit error count into 32 bits
package sweep_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        APPLY   = 3'd1,
        SETTLE  = 3'd2,
        CLEAR   = 3'd3,
        WINDOW  = 3'd4,
        DRAIN   = 3'd5,
        CAPTURE = 3'd6,
        NEXT    = 3'd7
    } state_t;

    localparam logic [7:0] MODE_OFF = 8'd255;

    function automatic logic [31:0] sat_err32(input logic [63:0] v);
        return (v[63:32] != 32'd0) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

endpackage

// File: rtl/sweep_timer.sv
// sweep_timer: loadable down-counter shared by the settle, clear, window and
// drain phases. A load of N gives N+1 cycles before and including zero=1.
//   CLK, RSTX  - clock, asynchronous active-low reset
//   load       - load load_val this cycle (takes priority over counting)
//   load_val   - value to load
//   zero       - count has reached zero (counter holds at zero)
module sweep_timer #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RSTX,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: steps the stimulus block through every (main, sub) mode pair in
// a range, lets each point settle, clears the link counters, measures for a
// window, waits for the counters to drain, then reports pass/fail per point.
// Optional feature: define SWEEP_CTRL_EARLY_STOP_EN to end the sweep at the
// first failing point (modes are held at that point).
// Ports:
//   CLK, RSTX                  - clock, asynchronous active-low reset
//   START, ABORT               - sweep request / immediate stop
//   MAIN_FIRST/LAST, SUB_LAST  - sweep range (latched at START)
//   SETTLE_CYC, WINDOW_CYC     - per-point timing (latched at START)
//   RECV_CNT, ERR_CNT          - link counters
//   MAIN_MODE, SUB_MODE, CLR   - registered drive to stimulus / counters
//   BUSY, DONE                 - status; DONE is a one-cycle pulse
//   RES_*                      - per-point result, qualified by RES_VLD pulse
//   FAIL_CNT                   - failing points this sweep, saturating
//   STATE                      - current FSM state (debug)
// Handshake: START is sampled only in IDLE and is a one-cycle request; there
// is no back-pressure, every RES_VLD/DONE is a single-cycle pulse that the
// consumer must take in that cycle.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int SETTLE_W  = 16,
    parameter int WIN_W     = 32,
    parameter int CLR_LEN   = 8,
    parameter int DRAIN_LEN = 16
) (
    input  logic                CLK,
    input  logic                RSTX,
    input  logic                START,
    input  logic                ABORT,
    input  logic [7:0]          MAIN_FIRST,
    input  logic [7:0]          MAIN_LAST,
    input  logic [7:0]          SUB_LAST,
    input  logic [SETTLE_W-1:0] SETTLE_CYC,
    input  logic [WIN_W-1:0]    WINDOW_CYC,
    input  logic [57:0]         RECV_CNT,
    input  logic [63:0]         ERR_CNT,
    output logic [7:0]          MAIN_MODE,
    output logic [7:0]          SUB_MODE,
    output logic                CLR,
    output logic                BUSY,
    output logic                DONE,
    output logic                RES_VLD,
    output logic [7:0]          RES_MAIN,
    output logic [7:0]          RES_SUB,
    output logic                RES_PASS,
    output logic [31:0]         RES_ERR,
    output logic [15:0]         FAIL_CNT,
    output logic [2:0]          STATE
);

    localparam int TW = (SETTLE_W > WIN_W) ? SETTLE_W : WIN_W;
    localparam logic [TW-1:0] CLR_VAL   = TW'(CLR_LEN - 1);
    localparam logic [TW-1:0] DRAIN_VAL = TW'(DRAIN_LEN - 1);

    state_t              state;
    logic [7:0]          main_last_q;
    logic [7:0]          sub_last_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [WIN_W-1:0]    window_q;

    logic                tmr_load;
    logic [TW-1:0]       tmr_val;
    logic                tmr_zero;
    logic                pass_now;

    assign STATE    = state;
    assign pass_now = (ERR_CNT == 64'd0) && (RECV_CNT != 58'd0);

    // Timer loads happen on the edge that leaves a phase, with the length of
    // the phase being entered minus one (a zero-length settle skips SETTLE,
    // a zero-length window still lasts one cycle).
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            APPLY: begin
                tmr_load = 1'b1;
                tmr_val  = (settle_q == '0) ? CLR_VAL : TW'(settle_q) - TW'(1);
            end
            SETTLE: begin
                tmr_load = tmr_zero;
                tmr_val  = CLR_VAL;
            end
            CLEAR: begin
                tmr_load = tmr_zero;
                tmr_val  = (window_q == '0) ? '0 : TW'(window_q) - TW'(1);
            end
            WINDOW: begin
                tmr_load = tmr_zero;
                tmr_val  = DRAIN_VAL;
            end
            default: begin
                tmr_load = 1'b0;
                tmr_val  = '0;
            end
        endcase
    end

    sweep_timer #(.W(TW)) u_timer (
        .CLK      (CLK),
        .RSTX     (RSTX),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state       <= IDLE;
            main_last_q <= 8'd0;
            sub_last_q  <= 8'd0;
            settle_q    <= '0;
            window_q    <= '0;
            MAIN_MODE   <= MODE_OFF;
            SUB_MODE    <= 8'd0;
            CLR         <= 1'b1;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            RES_VLD     <= 1'b0;
            RES_MAIN    <= 8'd0;
            RES_SUB     <= 8'd0;
            RES_PASS    <= 1'b0;
            RES_ERR     <= 32'd0;
            FAIL_CNT    <= 16'd0;
        end else begin
            DONE    <= 1'b0;
            RES_VLD <= 1'b0;
            if (ABORT && state != IDLE) begin
                state <= IDLE;
                CLR   <= 1'b0;
                BUSY  <= 1'b0;
                DONE  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        CLR <= 1'b0;
                        if (START && !ABORT) begin
                            main_last_q <= MAIN_LAST;
                            sub_last_q  <= SUB_LAST;
                            settle_q    <= SETTLE_CYC;
                            window_q    <= WINDOW_CYC;
                            FAIL_CNT    <= 16'd0;
                            if (MAIN_FIRST > MAIN_LAST) begin
                                DONE <= 1'b1;
                            end else begin
                                MAIN_MODE <= MAIN_FIRST;
                                SUB_MODE  <= 8'd0;
                                BUSY      <= 1'b1;
                                state     <= APPLY;
                            end
                        end
                    end
                    APPLY: begin
                        if (settle_q == '0) begin
                            CLR   <= 1'b1;
                            state <= CLEAR;
                        end else begin
                            state <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        if (tmr_zero) begin
                            CLR   <= 1'b1;
                            state <= CLEAR;
                        end
                    end
                    CLEAR: begin
                        if (tmr_zero) begin
                            CLR   <= 1'b0;
                            state <= WINDOW;
                        end
                    end
                    WINDOW: begin
                        if (tmr_zero) state <= DRAIN;
                    end
                    DRAIN: begin
                        if (tmr_zero) state <= CAPTURE;
                    end
                    CAPTURE: begin
                        RES_VLD  <= 1'b1;
                        RES_MAIN <= MAIN_MODE;
                        RES_SUB  <= SUB_MODE;
                        RES_PASS <= pass_now;
                        RES_ERR  <= sat_err32(ERR_CNT);
                        if (!pass_now && FAIL_CNT != 16'hFFFF)
                            FAIL_CNT <= FAIL_CNT + 16'd1;
                        state <= NEXT;
                    end
                    NEXT: begin
                        // The last-point test comes before any increment, so
                        // MAIN_LAST=255 ends the sweep instead of wrapping.
`ifdef SWEEP_CTRL_EARLY_STOP_EN
                        if (!RES_PASS ||
                            (MAIN_MODE == main_last_q && SUB_MODE == sub_last_q)) begin
`else
                        if (MAIN_MODE == main_last_q && SUB_MODE == sub_last_q) begin
`endif
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            if (SUB_MODE < sub_last_q) begin
                                SUB_MODE <= SUB_MODE + 8'd1;
                            end else begin
                                SUB_MODE  <= 8'd0;
                                MAIN_MODE <= MAIN_MODE + 8'd1;
                            end
                            state <= APPLY;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: directed scenarios for sweep_ctrl with a result scoreboard.
module tb_sweep_ctrl;

    logic        CLK = 1'b0;
    logic        RSTX = 1'b0;
    logic        START = 1'b0;
    logic        ABORT = 1'b0;
    logic [7:0]  MAIN_FIRST = 8'd0;
    logic [7:0]  MAIN_LAST = 8'd0;
    logic [7:0]  SUB_LAST = 8'd0;
    logic [15:0] SETTLE_CYC = 16'd0;
    logic [31:0] WINDOW_CYC = 32'd0;
    logic [57:0] RECV_CNT = 58'd100;
    logic [63:0] ERR_CNT;
    logic [7:0]  MAIN_MODE, SUB_MODE, RES_MAIN, RES_SUB;
    logic        CLR, BUSY, DONE, RES_VLD, RES_PASS;
    logic [31:0] RES_ERR;
    logic [15:0] FAIL_CNT;
    logic [2:0]  STATE;

    // error-counter model: a base value plus one optional faulty point
    logic [63:0] err_base = 64'd0;
    logic        err_pt_en = 1'b0;
    logic [7:0]  err_pt_main = 8'd0;
    logic [7:0]  err_pt_sub = 8'd0;
    logic [63:0] err_pt_val = 64'd0;

    always_comb begin
        ERR_CNT = err_base;
        if (err_pt_en && MAIN_MODE == err_pt_main && SUB_MODE == err_pt_sub)
            ERR_CNT = err_pt_val;
    end

    sweep_ctrl dut (
        .CLK(CLK), .RSTX(RSTX), .START(START), .ABORT(ABORT),
        .MAIN_FIRST(MAIN_FIRST), .MAIN_LAST(MAIN_LAST), .SUB_LAST(SUB_LAST),
        .SETTLE_CYC(SETTLE_CYC), .WINDOW_CYC(WINDOW_CYC),
        .RECV_CNT(RECV_CNT), .ERR_CNT(ERR_CNT),
        .MAIN_MODE(MAIN_MODE), .SUB_MODE(SUB_MODE), .CLR(CLR),
        .BUSY(BUSY), .DONE(DONE), .RES_VLD(RES_VLD), .RES_MAIN(RES_MAIN),
        .RES_SUB(RES_SUB), .RES_PASS(RES_PASS), .RES_ERR(RES_ERR),
        .FAIL_CNT(FAIL_CNT), .STATE(STATE)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [48:0] exp_q[$];
    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int vld_cnt = 0;
    int first_vld_cyc = -1;
    int last_vld_cyc = 0;
    int clr_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] m, input logic [7:0] s,
                            input logic p, input logic [31:0] e);
        exp_q.push_back({m, s, p, e});
    endtask

    // monitor: pops one expected result for every RES_VLD pulse
    always @(negedge CLK) begin
        if (RSTX) begin
            if (CLR) clr_cnt++;
            if (DONE) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (RES_VLD) begin
                logic [48:0] e;
                vld_cnt++;
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
                last_vld_cyc = cyc;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: got main=%0d sub=%0d pass=%0b err=0x%0h with none expected",
                             RES_MAIN, RES_SUB, RES_PASS, RES_ERR);
                end else begin
                    e = exp_q.pop_front();
                    if ({RES_MAIN, RES_SUB, RES_PASS, RES_ERR} !== e) begin
                        n_fail++;
                        $display("FAIL result: got main=%0d sub=%0d pass=%0b err=0x%0h expected main=%0d sub=%0d pass=%0b err=0x%0h",
                                 RES_MAIN, RES_SUB, RES_PASS, RES_ERR,
                                 e[48:41], e[40:33], e[32], e[31:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    int start_c = 0;

    task automatic start_sweep(input logic [7:0] mf, input logic [7:0] ml, input logic [7:0] sl,
                               input logic [15:0] st, input logic [31:0] wn);
        @(negedge CLK);
        MAIN_FIRST = mf; MAIN_LAST = ml; SUB_LAST = sl;
        SETTLE_CYC = st; WINDOW_CYC = wn;
        first_vld_cyc = -1;
        vld_cnt = 0;
        start_c = cyc;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge CLK);
            n++;
        end
        n_tests++;
        if (done_cnt < target) begin
            n_fail++;
            $display("FAIL %s: DONE count %0d after %0d cycles, required %0d", name, done_cnt, n, target);
        end
        @(negedge CLK);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        while (STATE != s && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(name, {61'd0, STATE}, {61'd0, s});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d0;
        // reset values
        repeat (3) @(negedge CLK);
        check("rst_main", MAIN_MODE, 8'd255);
        check("rst_sub", SUB_MODE, 8'd0);
        check("rst_clr", CLR, 1'b1);
        check("rst_busy_done_vld", {BUSY, DONE, RES_VLD}, 3'b000);
        check("rst_res", {RES_MAIN, RES_SUB, RES_PASS, RES_ERR}, 49'd0);
        check("rst_fail_cnt", FAIL_CNT, 16'd0);
        RSTX = 1'b1;
        @(negedge CLK);
        check("clr_drop_after_rst", CLR, 1'b0);

        // basic 2x2 sweep, all passing; inputs changed mid-sweep and a
        // second START must both be ignored
        clr_cnt = 0;
        d0 = done_cnt;
        push_exp(8'd9, 8'd0, 1'b1, 32'd0);
        push_exp(8'd9, 8'd1, 1'b1, 32'd0);
        push_exp(8'd10, 8'd0, 1'b1, 32'd0);
        push_exp(8'd10, 8'd1, 1'b1, 32'd0);
        start_sweep(8'd9, 8'd10, 8'd1, 16'd4, 32'd10);
        check("busy_after_start", BUSY, 1'b1);
        MAIN_FIRST = 8'd0; MAIN_LAST = 8'd200; SUB_LAST = 8'd5;
        repeat (20) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_done(d0 + 1, 400, "basic_done");
        check("basic_latency", first_vld_cyc, start_c + 41);
        check("basic_results", vld_cnt, 4);
        check("basic_queue_empty", exp_q.size(), 0);
        check("basic_fail_cnt", FAIL_CNT, 16'd0);
        check("basic_one_done", done_cnt - d0, 1);
        check("basic_clr_cycles", clr_cnt, 32);
        check("basic_idle", {BUSY, STATE}, 4'd0);
        check("basic_done_after_vld", done_cyc, last_vld_cyc + 1);

        // one failing point at (13,2)
        d0 = done_cnt;
        err_pt_en = 1'b1; err_pt_main = 8'd13; err_pt_sub = 8'd2; err_pt_val = 64'd5;
        push_exp(8'd13, 8'd0, 1'b1, 32'd0);
        push_exp(8'd13, 8'd1, 1'b1, 32'd0);
        push_exp(8'd13, 8'd2, 1'b0, 32'd5);
`ifndef SWEEP_CTRL_EARLY_STOP_EN
        push_exp(8'd14, 8'd0, 1'b1, 32'd0);
        push_exp(8'd14, 8'd1, 1'b1, 32'd0);
        push_exp(8'd14, 8'd2, 1'b1, 32'd0);
`endif
        start_sweep(8'd13, 8'd14, 8'd2, 16'd2, 32'd3);
        wait_done(d0 + 1, 400, "fail_pt_done");
        check("fail_pt_queue_empty", exp_q.size(), 0);
        check("fail_pt_fail_cnt", FAIL_CNT, 16'd1);
        check("fail_pt_done_after_vld", done_cyc, last_vld_cyc + 1);
        check("fail_pt_sub_hold", SUB_MODE, 8'd2);
`ifdef SWEEP_CTRL_EARLY_STOP_EN
        check("fail_pt_main_hold", MAIN_MODE, 8'd13);
`else
        check("fail_pt_main_hold", MAIN_MODE, 8'd14);
`endif
        err_pt_en = 1'b0;

        // abort during WINDOW
        d0 = done_cnt;
        start_sweep(8'd1, 8'd3, 8'd1, 16'd3, 32'd20);
        wait_state(3'd4, 100, "abort_reach_window");
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("abort_state_idle", STATE, 3'd0);
        check("abort_done_pulse", DONE, 1'b1);
        check("abort_clr_busy", {CLR, BUSY}, 2'b00);
        repeat (60) @(negedge CLK);
        check("abort_no_result", vld_cnt, 0);
        check("abort_one_done", done_cnt - d0, 1);

        // empty range
        d0 = done_cnt;
        start_sweep(8'd20, 8'd19, 8'd0, 16'd1, 32'd1);
        check("empty_done_next", DONE, 1'b1);
        check("empty_busy", BUSY, 1'b0);
        repeat (10) @(negedge CLK);
        check("empty_no_result", vld_cnt, 0);
        check("empty_one_done", done_cnt - d0, 1);

        // top of range, no wrap
        d0 = done_cnt;
        push_exp(8'd255, 8'd0, 1'b1, 32'd0);
        start_sweep(8'd255, 8'd255, 8'd0, 16'd1, 32'd2);
        wait_done(d0 + 1, 200, "top_done");
        repeat (60) @(negedge CLK);
        check("top_one_result", vld_cnt, 1);
        check("top_main_hold", MAIN_MODE, 8'd255);
        check("top_idle", STATE, 3'd0);

        // huge error count saturates; zero settle / zero window timing
        d0 = done_cnt;
        err_base = 64'd1 << 40;
        push_exp(8'd30, 8'd0, 1'b0, 32'hFFFF_FFFF);
        start_sweep(8'd30, 8'd30, 8'd0, 16'd0, 32'd0);
        wait_done(d0 + 1, 200, "sat_done");
        check("sat_latency", first_vld_cyc, start_c + 28);
        check("sat_fail_cnt", FAIL_CNT, 16'd1);
        err_base = 64'd0;

        // no traffic received counts as a failure
        d0 = done_cnt;
        RECV_CNT = 58'd0;
        push_exp(8'd31, 8'd0, 1'b0, 32'd0);
        start_sweep(8'd31, 8'd31, 8'd0, 16'd1, 32'd1);
        wait_done(d0 + 1, 200, "norecv_done");
        check("norecv_fail_cnt", FAIL_CNT, 16'd1);
        RECV_CNT = 58'd100;

        // ABORT and START together in IDLE: nothing starts
        @(negedge CLK);
        START = 1'b1; ABORT = 1'b1;
        @(negedge CLK);
        START = 1'b0; ABORT = 1'b0;
        check("abort_over_start", {BUSY, STATE}, 4'd0);

        // reset mid-SETTLE
        start_sweep(8'd40, 8'd41, 8'd0, 16'd30, 32'd5);
        wait_state(3'd2, 20, "rst_reach_settle");
        RSTX = 1'b0;
        #1;
        check("midrst_main", MAIN_MODE, 8'd255);
        check("midrst_clr", CLR, 1'b1);
        check("midrst_busy_state", {BUSY, STATE}, 4'd0);
        @(negedge CLK);
        RSTX = 1'b1;
        repeat (100) @(negedge CLK);
        check("midrst_no_result", vld_cnt, 0);
        check("midrst_idle", {CLR, BUSY, STATE}, 5'd0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
